// File: rtl/wb_v_scheduler_pkg.sv
// Shared definitions for the vector write-back scheduler: default sizes,
// RS_v kind encodings and FSM state type.
package wb_v_scheduler_pkg;

  localparam int WB_RS_SIZE   = 8;
  localparam int WB_LANE_SIZE = 8;
  localparam int WB_BEATS     = 4;

  typedef enum logic [1:0] {
    WB_KIND_LOAD  = 2'b00,
    WB_KIND_STORE = 2'b01,
    WB_KIND_ALU   = 2'b10,
    WB_KIND_INV   = 2'b11
  } wb_kind_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } wb_state_e;

  function automatic logic wb_kind_valid(input logic [1:0] kind);
    return kind != WB_KIND_INV;
  endfunction

endpackage

// File: rtl/wb_v_rr_pick.sv
// Combinational picker: first set bit of i_elig searching upward from i_ptr,
// wrapping modulo N. With i_ptr tied to 0 this is plain lowest-index priority.
module wb_v_rr_pick
  import wb_v_scheduler_pkg::*;
#(
  parameter int N     = WB_RS_SIZE,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_elig,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_any,
  output logic [IDX_W-1:0] o_idx
);

  always_comb begin
    int pos;
    pos   = 0;
    o_any = 1'b0;
    o_idx = '0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(i_ptr) + k) % N;
      if (!o_any && i_elig[pos]) begin
        o_any = 1'b1;
        o_idx = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/wb_v_scheduler.sv
// Vector write-back scheduler: grants one completed RS_v entry at a time and
// runs it through a locked BEATS-beat burst. Define WB_V_RR_EN for round-robin.
module wb_v_scheduler
  import wb_v_scheduler_pkg::*;
#(
  parameter int RS_SIZE   = WB_RS_SIZE,
  parameter int LANE_SIZE = WB_LANE_SIZE,
  parameter int BEATS     = WB_BEATS,
  parameter int IDX_W     = $clog2(RS_SIZE),
  parameter int BEAT_W    = $clog2(BEATS),
  parameter int LB_W      = BEAT_W + $clog2(LANE_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RS_SIZE-1:0]     req,
  input  logic [2*RS_SIZE-1:0]   req_kind,
  input  logic                   wb_stall,
  output logic                   wb_valid,
  output logic [IDX_W-1:0]       wb_rs_idx,
  output logic [1:0]             wb_kind,
  output logic [BEAT_W-1:0]      wb_beat,
  output logic [LB_W-1:0]        wb_lane_base,
  output logic [RS_SIZE-1:0]     rs_clear,
  output logic                   store_done,
  output logic                   busy
);

  wb_state_e          r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [1:0]         r_kind;
  logic [BEAT_W-1:0]  r_beat;
  logic [RS_SIZE-1:0] r_rs_clear;
  logic               r_store_done;
  logic               r_mask_valid;
  logic [IDX_W-1:0]   r_mask_idx;

  logic [RS_SIZE-1:0] w_elig;
  logic               w_accept;
  logic               w_final;
  logic               w_any;
  logic               w_grant;
  logic [IDX_W-1:0]   w_pick;
  logic [1:0]         w_pick_kind;
  logic [IDX_W-1:0]   w_ptr;
  logic [IDX_W-1:0]   w_next_ptr;

  assign w_accept = (r_state == ST_BURST) && !wb_stall;
  assign w_final  = w_accept && (r_beat == BEAT_W'(BEATS - 1));

  // The completing entry is excluded in its final-accept cycle; from then on
  // the mask keeps it out until the RS drops its request.
  for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_elig
    assign w_elig[gi] = req[gi]
                     && wb_kind_valid(req_kind[2*gi +: 2])
                     && !(r_mask_valid && (r_mask_idx == IDX_W'(gi)))
                     && !(w_final && (r_idx == IDX_W'(gi)));
  end

  wb_v_rr_pick #(
    .N     (RS_SIZE),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_elig (w_elig),
    .i_ptr  (w_ptr),
    .o_any  (w_any),
    .o_idx  (w_pick)
  );

  assign w_pick_kind = req_kind[int'(w_pick)*2 +: 2];
  assign w_grant     = w_any && ((r_state == ST_IDLE) || w_final);
  assign w_next_ptr  = (w_pick == IDX_W'(RS_SIZE - 1)) ? '0 : w_pick + 1'b1;

`ifdef WB_V_RR_EN
  logic [IDX_W-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= w_next_ptr;
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_kind       <= '0;
      r_beat       <= '0;
      r_rs_clear   <= '0;
      r_store_done <= 1'b0;
      r_mask_valid <= 1'b0;
      r_mask_idx   <= '0;
    end else begin
      r_rs_clear   <= '0;
      r_store_done <= 1'b0;
      if (r_mask_valid && !req[r_mask_idx]) begin
        r_mask_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state <= ST_BURST;
            r_idx   <= w_pick;
            r_kind  <= w_pick_kind;
            r_beat  <= '0;
          end
        end
        ST_BURST: begin
          if (w_final) begin
            r_rs_clear   <= RS_SIZE'(1) << r_idx;
            r_store_done <= (r_kind == WB_KIND_STORE);
            r_mask_valid <= 1'b1;
            r_mask_idx   <= r_idx;
            r_beat       <= '0;
            if (w_grant) begin
              r_idx  <= w_pick;
              r_kind <= w_pick_kind;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (w_accept) begin
            r_beat <= r_beat + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wb_valid     = (r_state == ST_BURST);
  assign busy         = (r_state == ST_BURST);
  assign wb_rs_idx    = r_idx;
  assign wb_kind      = r_kind;
  assign wb_beat      = r_beat;
  assign wb_lane_base = LB_W'(r_beat) * LB_W'(LANE_SIZE);
  assign rs_clear     = r_rs_clear;
  assign store_done   = r_store_done;

endmodule

// File: doc/wb_v_scheduler.md
Name: wb_v_scheduler

Overview:
- Arbitrates the single vector write-back port among reservation-station (RS_v) entries whose execution is complete.
- Sequences each granted entry through a locked burst of BEATS beats. Each beat carries LANE_SIZE elements.
- On completion it issues the RS clear and the store-done pulses.
- Sits between the RS_v table and the write-back datapath (ARF_vector write, data_mem store).

Parameters:
- RS_SIZE, 8, number of RS_v entries.
- LANE_SIZE, 8, elements written per beat.
- BEATS, 4, beats per vector (32 elements total); must be a power of 2.
- IDX_W, $clog2(RS_SIZE), RS index width.
- BEAT_W, $clog2(BEATS), beat counter width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- req  in  RS_SIZE  bit i = RS entry i is busy and ex-complete.
- req_kind  in  2*RS_SIZE  kind of entry i at bits [2i+1:2i]: 00 load, 01 store, 10 add/sub, 11 invalid.
- wb_stall  in  1  datapath cannot accept the current beat.
- wb_valid  out  1  a beat is presented this cycle.
- wb_rs_idx  out  IDX_W  granted RS index.
- wb_kind  out  2  kind of the granted entry, latched at grant.
- wb_beat  out  BEAT_W  current beat number.
- wb_lane_base  out  BEAT_W+$clog2(LANE_SIZE)  equals wb_beat*LANE_SIZE.
- rs_clear  out  RS_SIZE  one-hot, 1-cycle pulse: clear this RS entry.
- store_done  out  1  1-cycle pulse when a store burst completes.
- busy  out  1  FSM is in BURST.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, beat counter 0, round-robin pointer 0, completion mask invalid.
- Eligibility: req[i]=1, kind!=11, and i is not the masked completed index.
- FSM states:
  - IDLE: if any entry is eligible, latch the selected index and its kind, set beat=0, go to BURST. wb_valid rises the next cycle, so there is 1-cycle latency from req to the first beat.
  - BURST: wb_valid=1. Beat accepted = wb_valid & !wb_stall.
    - Accepted and beat<BEATS-1: beat increments.
    - Accepted and beat==BEATS-1 (final accept):
      - next cycle rs_clear[idx]=1;
      - store_done=1 if kind was 01;
      - completed idx is loaded into the mask.
    - After a final accept with another entry eligible (the completing idx is excluded in that same cycle), grant it directly: BURST beat 0 the next cycle, no idle bubble. Otherwise return to IDLE.
- Stall: wb_stall holds the beat, index and kind stable; wb_valid stays 1. A stall of any length is legal.
- Lock: once granted, the burst runs to completion even if req[idx] drops or req_kind changes mid-burst.
- Mask: cleared when req[masked idx]==0 is sampled. This stops an entry being re-granted before the RS applies rs_clear.
- Arithmetic: the beat counter wraps modulo BEATS. wb_lane_base is combinational from the registered beat.
- Invalid kind (11): never granted. The request is silently skipped.
- Reset mid-burst: abort immediately. No rs_clear or store_done is issued; the partially written vector is the RS owner's concern.
- Output registration: rs_clear and store_done are registered. They cannot overlap the next burst's beat-0 decision on the same index.

Optional Feature:
- Macro: WB_V_RR_EN.
- Defined: round-robin arbitration. The search starts at ptr. On each grant, ptr = granted idx + 1, modulo RS_SIZE.
- Undefined: fixed priority, lowest eligible index wins. No pointer is kept.

Decomposition:
- Shared package / definitions include:
  - kind encodings WB_KIND_LOAD=2'b00, WB_KIND_STORE=2'b01, WB_KIND_ALU=2'b10, WB_KIND_INV=2'b11;
  - RS_SIZE, LANE_SIZE, BEATS defaults.
- One sub-module, wb_v_rr_pick:
  - combinational pick of one index from an eligible vector, starting at ptr (ptr tied to 0 when WB_V_RR_EN is undefined);
  - outputs any-valid and the index.
- FSM, counter and mask stay in wb_v_scheduler.

Test Plan:
- Single load: req=8'b0000_0100, kind[2]=00, no stall.
  - wb_valid for 4 cycles with wb_rs_idx=2, beats 0..3, lane_base 0/8/16/24.
  - rs_clear=8'b0000_0100 one cycle after beat 3; store_done=0.
- Store with stall: req[5], kind=01; wb_stall=1 during beat 1 for 3 cycles.
  - beat 1 is held for 4 cycles total;
  - 7 wb_valid cycles overall; store_done=1 and rs_clear[5]=1 after beat 3.
- Back-to-back: req[1] and req[6] are ALU at the same time, RR_EN defined, ptr=0.
  - 1 granted, then 6 immediately follows with no IDLE cycle;
  - entry 1 is not re-granted while req[1] stays high for 1 cycle after rs_clear.
- Fixed priority (RR_EN undefined): req[3] and req[0] held continuously, each held req dropped after its rs_clear.
  - order is 0 then 3;
  - with RR_EN defined and ptr=1, the order is 3 then 0.
- Invalid kind: req[4]=1, kind=11 -> wb_valid remains 0 and busy=0.
- Reset mid-burst: assert rst during beat 2.
  - next cycle all outputs are 0 and no rs_clear is issued;
  - after rst deasserts with req still high, the burst restarts at beat 0.
